// File: rtl/sii_ncu_tx_pkg.sv
// Shared definitions for the SII-to-NCU inbound transmit path: header layout,
// payload beat count, transmit FSM states and the parity helper.
package sii_ncu_pkg;

  localparam int SII_NCU_TYPE_W   = 3;
  localparam int SII_NCU_ID_W     = 4;
  localparam int SII_NCU_INFO_W   = 9;
  localparam int SII_NCU_TYPE_LSB = 13;
  localparam int SII_NCU_ID_LSB   = 9;
  localparam int SII_NCU_INFO_LSB = 0;
  localparam int SII_NCU_HDR_W    = SII_NCU_TYPE_W + SII_NCU_ID_W + SII_NCU_INFO_W;
  localparam int SII_NCU_PL_W     = 128;
  localparam int SII_NCU_PKT_W    = SII_NCU_HDR_W + SII_NCU_PL_W;
  localparam int SII_NCU_BUS_W    = 32;
  localparam int SII_NCU_PL_BEATS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_PL
  } tx_state_e;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_par16(input logic [15:0] half);
    return ^half;
  endfunction

  function automatic logic [1:0] bus_par(input logic [SII_NCU_BUS_W-1:0] word);
    return {even_par16(word[31:16]), even_par16(word[15:0])};
  endfunction

endpackage

// File: rtl/sii_ncu_tx_fifo.sv
// QDEPTH-entry (1 or 2) packet queue holding header fields plus payload,
// with registered ready and occupancy count.
module sii_ncu_tx_fifo
  import sii_ncu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                     iol2clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [SII_NCU_PKT_W-1:0] push_data,
  input  logic                     pop,
  output logic [SII_NCU_PKT_W-1:0] head,
  output logic                     rdy,
  output logic [1:0]               count
);

  logic [SII_NCU_PKT_W-1:0] mem [QDEPTH];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               count_nxt;

  function automatic logic ptr_inc(input logic p);
    return (int'(p) == QDEPTH - 1) ? 1'b0 : ~p;
  endfunction

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 2'd1;
    else if (!push && pop) count_nxt = count - 2'd1;
  end

  assign head = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, so flushing them is sufficient.
  always_ff @(posedge iol2clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Ready is computed from the next count so it never depends on pkt_vld
  // combinationally, and it reopens the cycle after a pop from full.
  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      rdy    <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      rdy   <= (int'(count_nxt) < QDEPTH);
    end
  end

endmodule

// File: rtl/sii_ncu_tx.sv
// SII-to-NCU inbound transmitter: queues packets, runs req/gnt, then sends a
// header beat and four payload beats with per-halfword even parity.
// Optional build macro SII_NCU_TX_PERR_INJ_EN enables payload parity-error injection.
module sii_ncu_tx
  import sii_ncu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      iol2clk,
  input  logic                      rst,
  input  logic                      pkt_vld,
  output logic                      pkt_rdy,
  input  logic [SII_NCU_TYPE_W-1:0] pkt_type,
  input  logic [SII_NCU_ID_W-1:0]   pkt_id,
  input  logic [SII_NCU_INFO_W-1:0] pkt_info,
  input  logic [SII_NCU_PL_W-1:0]   pkt_data,
  input  logic                      perr_inj,
  output logic                      sii_ncu_req,
  input  logic                      ncu_sii_gnt,
  output logic [SII_NCU_BUS_W-1:0]  sii_ncu_data,
  output logic [1:0]                sii_ncu_dparity,
  output logic                      tx_done,
  output logic                      proto_err
);

  tx_state_e                state;
  logic [1:0]               beat;
  logic [SII_NCU_PL_W-1:0]  shift;
  logic                     push;
  logic                     pop;
  logic                     pending;
  logic [SII_NCU_PKT_W-1:0] head;
  logic [1:0]               count;
  logic [SII_NCU_BUS_W-1:0] hdr_word;
  logic                     beat0_perr;

  assign push     = pkt_vld && pkt_rdy;
  assign pop      = (state == ST_REQ) && ncu_sii_gnt;
  // A packet arriving this very edge counts as queued, so req can rise with it.
  assign pending  = push || (count != 2'd0);
  assign hdr_word = {{(SII_NCU_BUS_W - SII_NCU_HDR_W){1'b0}},
                     head[SII_NCU_PKT_W-1 -: SII_NCU_HDR_W]};

`ifdef SII_NCU_TX_PERR_INJ_EN
  assign beat0_perr = perr_inj;
`else
  assign beat0_perr = perr_inj & 1'b0;
`endif

  sii_ncu_tx_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .iol2clk   (iol2clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pkt_type, pkt_id, pkt_info, pkt_data}),
    .pop       (pop),
    .head      (head),
    .rdy       (pkt_rdy),
    .count     (count)
  );

  // The last payload beat is launched on the way out of PL, so the next req
  // (or return to idle) coincides with beat 3 on the bus.
  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      beat            <= 2'd0;
      shift           <= '0;
      sii_ncu_req     <= 1'b0;
      sii_ncu_data    <= '0;
      sii_ncu_dparity <= 2'b00;
      tx_done         <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sii_ncu_data    <= '0;
          sii_ncu_dparity <= 2'b00;
          if (ncu_sii_gnt) proto_err <= 1'b1;
          if (pending) begin
            state       <= ST_REQ;
            sii_ncu_req <= 1'b1;
          end
        end
        ST_REQ: begin
          sii_ncu_data    <= '0;
          sii_ncu_dparity <= 2'b00;
          if (ncu_sii_gnt) begin
            state           <= ST_HDR;
            sii_ncu_req     <= 1'b0;
            shift           <= head[SII_NCU_PL_W-1:0];
            sii_ncu_data    <= hdr_word;
            sii_ncu_dparity <= bus_par(hdr_word);
          end
        end
        ST_HDR: begin
          if (ncu_sii_gnt) proto_err <= 1'b1;
          state           <= ST_PL;
          beat            <= 2'd0;
          sii_ncu_data    <= shift[SII_NCU_PL_W-1 -: SII_NCU_BUS_W];
          sii_ncu_dparity <= bus_par(shift[SII_NCU_PL_W-1 -: SII_NCU_BUS_W]) ^ {1'b0, beat0_perr};
          shift           <= {shift[SII_NCU_PL_W-SII_NCU_BUS_W-1:0], {SII_NCU_BUS_W{1'b0}}};
        end
        ST_PL: begin
          if (ncu_sii_gnt) proto_err <= 1'b1;
          beat            <= beat + 2'd1;
          sii_ncu_data    <= shift[SII_NCU_PL_W-1 -: SII_NCU_BUS_W];
          sii_ncu_dparity <= bus_par(shift[SII_NCU_PL_W-1 -: SII_NCU_BUS_W]);
          shift           <= {shift[SII_NCU_PL_W-SII_NCU_BUS_W-1:0], {SII_NCU_BUS_W{1'b0}}};
          if (beat == 2'(SII_NCU_PL_BEATS - 2)) begin
            tx_done     <= 1'b1;
            sii_ncu_req <= pending;
            state       <= pending ? ST_REQ : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
